// File: rtl/pipelined_select_addsub.sv
// Two-stage carry/borrow-select adder-subtractor with valid/ready flow.
// Ports: clk, rst, in_valid/in_ready, a, b, op_sub, sat_en,
//        out_valid/out_ready, result, overflow, cb_out.
module pipelined_select_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             cb_out
);
  localparam int NGRP = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("WIDTH must be >= 2 and a multiple of BLOCK");
  end

  logic             s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0] r0_d, r0_q, r1_d, r1_q;
  logic [NGRP-1:0]  cb0_d, cb0_q, cb1_d, cb1_q;
  logic             a_msb_d, a_msb_q;
  logic             b_msb_d, b_msb_q;
  logic             sub_d, sub_q;
  logic             sat_d, sat_q;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             overflow_d, overflow_q;
  logic             cb_out_d, cb_out_q;

  logic             s2_adv;
  logic [WIDTH-1:0] bx;
  logic [BLOCK:0]   sum0, sum1;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sat_val;
  logic             c;
  logic             bm;
  logic             ovf;
  logic             cb;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  // Subtract feeds ~b; the +1 comes from the chain carry-in.
  assign bx = op_sub ? ~b : b;

  always_comb begin
    s1_valid_d = s1_valid_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    cb0_d      = cb0_q;
    cb1_d      = cb1_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    sub_d      = sub_q;
    sat_d      = sat_q;
    sum0       = '0;
    sum1       = '0;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    // Data only loads on a real beat so idle X never enters.
    if (in_valid && in_ready) begin
      for (int g = 0; g < NGRP; g++) begin
        sum0 = {1'b0, a[g*BLOCK +: BLOCK]}
             + {1'b0, bx[g*BLOCK +: BLOCK]};
        sum1 = sum0 + (BLOCK+1)'(1);
        r0_d[g*BLOCK +: BLOCK] = sum0[BLOCK-1:0];
        r1_d[g*BLOCK +: BLOCK] = sum1[BLOCK-1:0];
        cb0_d[g] = sum0[BLOCK];
        cb1_d[g] = sum1[BLOCK];
      end
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      sub_d   = op_sub;
      sat_d   = sat_en;
    end
  end

  always_comb begin
    c   = sub_q;
    raw = '0;
    for (int g = 0; g < NGRP; g++) begin
      raw[g*BLOCK +: BLOCK] = c ? r1_q[g*BLOCK +: BLOCK]
                                : r0_q[g*BLOCK +: BLOCK];
      c = c ? cb1_q[g] : cb0_q[g];
    end
    bm      = sub_q ? ~b_msb_q : b_msb_q;
    ovf     = (a_msb_q == bm) && (raw[WIDTH-1] != a_msb_q);
    cb      = sub_q ? !c : c;
    sat_val = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};

    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    cb_out_d    = cb_out_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      result_d   = (sat_q && ovf) ? sat_val : raw;
      overflow_d = ovf;
      cb_out_d   = cb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      r0_q        <= '0;
      r1_q        <= '0;
      cb0_q       <= '0;
      cb1_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      sub_q       <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      cb_out_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      cb0_q       <= cb0_d;
      cb1_q       <= cb1_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      sub_q       <= sub_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      cb_out_q    <= cb_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign cb_out    = cb_out_q;

endmodule

// File: tb/tb_pipelined_select_addsub.sv
// Scoreboard bench: directed 16/2 instance plus random
// instances for 8/1, 16/2, 16/4 and 32/4.
module tb_pipelined_select_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  // Returns {ovf, cb, res[31:0]}.
  function automatic logic [33:0] model(input int w,
      input longint a, input longint b,
      input bit sub, input bit sat);
    longint one, lim, mask, sa, sb, s, mx, mn, raw;
    logic cb, ov;
    logic [31:0] r;
    one  = 1;
    lim  = one << w;
    mask = lim - 1;
    mx   = (one << (w - 1)) - 1;
    mn   = -(one << (w - 1));
    sa   = ((a >> (w - 1)) & 1) != 0 ? a - lim : a;
    sb   = ((b >> (w - 1)) & 1) != 0 ? b - lim : b;
    if (sub) begin
      cb  = (a < b);
      raw = (a - b) & mask;
      s   = sa - sb;
    end else begin
      cb  = (((a + b) >> w) & 1) != 0;
      raw = (a + b) & mask;
      s   = sa + sb;
    end
    ov = (s > mx) || (s < mn);
    if (ov && sat) raw = (s > mx) ? (mx & mask) : (mn & mask);
    r = 32'(raw);
    return {ov, cb, r};
  endfunction

  // ---------------- directed instance (16/2) ----------------
  logic        d_rst = 1'b1;
  logic        d_iv = 1'b0, d_ir;
  logic [15:0] d_a = '0, d_b = '0;
  logic        d_sub = 1'b0, d_sat = 1'b0;
  logic        d_ov, d_ory = 1'b0;
  logic [15:0] d_res;
  logic        d_ovf, d_cb;
  logic [17:0] d_q[$];

  pipelined_select_addsub #(.WIDTH(16), .BLOCK(2)) u_dut (
    .clk(clk), .rst(d_rst),
    .in_valid(d_iv), .in_ready(d_ir),
    .a(d_a), .b(d_b), .op_sub(d_sub), .sat_en(d_sat),
    .out_valid(d_ov), .out_ready(d_ory),
    .result(d_res), .overflow(d_ovf), .cb_out(d_cb)
  );

  always @(negedge clk) begin
    logic [17:0] e;
    #2;
    if (d_ov && d_ory) begin
      if (d_q.size() == 0) begin
        check("d_unexpected_beat", 1, 0);
      end else begin
        e = d_q.pop_front();
        check("d_result", d_res, e[15:0]);
        check("d_overflow", d_ovf, e[17]);
        check("d_cb_out", d_cb, e[16]);
      end
    end
  end

  task automatic push_beat(input logic [15:0] a, input logic [15:0] b,
      input bit sub, input bit sat, input logic [15:0] er,
      input bit eo, input bit ec);
    int n;
    @(negedge clk);
    d_iv = 1'b1; d_a = a; d_b = b; d_sub = sub; d_sat = sat;
    #1;
    n = 0;
    while (!d_ir && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!d_ir) check("d_accept_timeout", 0, 1);
    else d_q.push_back({eo, ec, er});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d_iv = 1'b0;
      d_a = 'x;
      d_b = 'x;
    end
  endtask

  // ---------------- random instances ----------------
  logic r_rst = 1'b1;
  localparam int NB = 2600;

  for (genvar k = 0; k < 4; k++) begin : g_rnd
    localparam int W = (k == 0) ? 8 : (k == 3) ? 32 : 16;
    localparam int B = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    logic         iv, ir, ov, ory, sub, sat, ovf, cb;
    logic [W-1:0] a, b, res;
    logic [33:0]  q[$];
    bit           done = 1'b0;

    pipelined_select_addsub #(.WIDTH(W), .BLOCK(B)) u_dut (
      .clk(clk), .rst(r_rst),
      .in_valid(iv), .in_ready(ir),
      .a(a), .b(b), .op_sub(sub), .sat_en(sat),
      .out_valid(ov), .out_ready(ory),
      .result(res), .overflow(ovf), .cb_out(cb)
    );

    initial begin
      int sent, n;
      iv = 1'b0; ory = 1'b0; a = '0; b = '0;
      sub = 1'b0; sat = 1'b0;
      sent = 0;
      wait (r_rst == 1'b0);
      while (sent < NB) begin
        @(negedge clk);
        ory = ($urandom_range(0, 3) != 0);
        iv  = ($urandom_range(0, 2) != 0);
        a   = W'($urandom);
        b   = W'($urandom);
        if ($urandom_range(0, 3) == 0) a = {1'b0, {(W-1){1'b1}}};
        if ($urandom_range(0, 3) == 0) b = {1'b1, {(W-1){1'b0}}};
        sub = $urandom_range(0, 1) != 0;
        sat = $urandom_range(0, 1) != 0;
        #1;
        if (iv && ir) begin
          q.push_back(model(W, longint'(a), longint'(b), sub, sat));
          sent++;
        end
      end
      @(negedge clk);
      iv = 1'b0;
      ory = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) check("rnd_drain_timeout", q.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      logic [33:0] e;
      #2;
      if (ov && ory) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check("rnd_result", longint'(res), longint'(e[W-1:0]));
          check("rnd_overflow", ovf, e[33]);
          check("rnd_cb_out", cb, e[32]);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] snap_r;
    logic        snap_o, snap_c;
    int          n;

    repeat (2) @(negedge clk);
    d_rst = 1'b0;
    r_rst = 1'b0;
    #1;
    check("reset_out_valid", d_ov, 0);
    check("reset_result", d_res, 0);
    check("reset_overflow", d_ovf, 0);
    check("reset_cb_out", d_cb, 0);
    check("reset_in_ready", d_ir, 1);

    // T1 with latency check
    d_ory = 1'b1;
    push_beat(16'h0005, 16'h0003, 1, 0, 16'h0002, 0, 0);
    @(negedge clk);
    d_iv = 1'b0;
    #1;
    check("t1_lat_cycle1", d_ov, 0);
    @(negedge clk);
    #1;
    check("t1_lat_cycle2", d_ov, 1);
    idle(2);

    // T2 / T3 back-to-back
    push_beat(16'h0003, 16'h0005, 1, 0, 16'hFFFE, 0, 1);
    push_beat(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 0);
    push_beat(16'h8000, 16'h0001, 1, 1, 16'h8000, 1, 0);
    push_beat(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 1, 0);
    push_beat(16'h7FFF, 16'h0001, 0, 1, 16'h7FFF, 1, 0);
    push_beat(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 0, 1);
    idle(4);

    // T4 stall with both stages full
    d_ory = 1'b0;
    push_beat(16'h0100, 16'h0023, 0, 0, 16'h0123, 0, 0);
    push_beat(16'h0200, 16'h0001, 1, 0, 16'h01FF, 0, 0);
    @(negedge clk);
    d_iv = 1'b1; d_a = 16'h1000; d_b = 16'h2000;
    d_sub = 1'b1; d_sat = 1'b0;
    #1;
    check("t4_in_ready_low", d_ir, 0);
    check("t4_out_valid", d_ov, 1);
    snap_r = d_res; snap_o = d_ovf; snap_c = d_cb;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t4_hold_valid", d_ov, 1);
      check("t4_hold_result", d_res, snap_r);
      check("t4_hold_ovf", d_ovf, snap_o);
      check("t4_hold_cb", d_cb, snap_c);
      check("t4_hold_in_ready", d_ir, 0);
    end
    @(negedge clk);
    d_ory = 1'b1;
    #1;
    check("t4_in_ready_back", d_ir, 1);
    d_q.push_back({1'b0, 1'b1, 16'hF000});
    idle(5);

    // T5 reset flush with two beats in flight
    d_ory = 1'b0;
    push_beat(16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0);
    push_beat(16'h4444, 16'h0004, 1, 0, 16'h4440, 0, 0);
    @(negedge clk);
    d_iv = 1'b0;
    d_rst = 1'b1;
    d_q.delete();
    @(negedge clk);
    d_rst = 1'b0;
    #1;
    check("t5_out_valid", d_ov, 0);
    check("t5_result", d_res, 0);
    check("t5_overflow", d_ovf, 0);
    check("t5_cb_out", d_cb, 0);
    check("t5_in_ready", d_ir, 1);
    d_ory = 1'b1;
    idle(4);
    check("t5_no_ghost", d_ov, 0);
    push_beat(16'h1234, 16'h0001, 0, 0, 16'h1235, 0, 0);
    idle(4);

    n = 0;
    while (!(g_rnd[0].done && g_rnd[1].done &&
             g_rnd[2].done && g_rnd[3].done) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) check("rnd_timeout", 0, 1);
    check("d_queue_empty", d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
